// File: rtl/fast_cmd_gen.sv
// fast_cmd_gen: 40 MHz BX counter with orbit sync, and an L1A generator with spacing and counters.
// Define FAST_CMD_EXT_ORBIT_EN to add orbit_sync_in, which realigns the BX counter to an external orbit.
`timescale 1ns/1ps
module fast_cmd_gen #(
  parameter int BX_PER_ORBIT = 3564
) (
  input  logic        clk40,
  input  logic        rst,
  input  logic        enable,
  input  logic [1:0]  l1a_mode,
  input  logic        l1a_request,
  input  logic [15:0] l1a_period,
  input  logic [11:0] l1a_bx,
  input  logic [7:0]  min_spacing,
  input  logic        count_clear,
`ifdef FAST_CMD_EXT_ORBIT_EN
  input  logic        orbit_sync_in,
`endif
  output logic [11:0] bx_count,
  output logic        orbit_sync,
  output logic        l1a_out,
  output logic        l1a_pending,
  output logic [31:0] l1a_count,
  output logic [15:0] l1a_dropped
);

  typedef enum logic [1:0] {
    MODE_OFF       = 2'd0,
    MODE_SOFTWARE  = 2'd1,
    MODE_PERIODIC  = 2'd2,
    MODE_BX_LOCKED = 2'd3
  } mode_t;

  localparam logic [11:0] BX_LAST  = 12'(BX_PER_ORBIT - 1);
  localparam logic [12:0] BX_LIMIT = 13'(BX_PER_ORBIT);

  mode_t       mode;
  logic        running;
  logic        orbit_restart;
  logic [15:0] period_cnt;
  logic [7:0]  holdoff;

  logic [11:0] bx_next;
  logic        cand_sw;
  logic        cand_periodic;
  logic        cand_bx;
  logic        issue;
  logic        drop;
  logic [15:0] period_next;
  logic [7:0]  holdoff_next;
  logic        pending_next;

  assign mode = mode_t'(l1a_mode);

`ifdef FAST_CMD_EXT_ORBIT_EN
  logic orbit_in_q;
  logic orbit_rise_q;

  // One-flop edge detect; the registered rise restarts the orbit on the following edge.
  always_ff @(posedge clk40 or posedge rst) begin
    if (rst) begin
      orbit_in_q   <= 1'b0;
      orbit_rise_q <= 1'b0;
    end else begin
      orbit_in_q   <= orbit_sync_in;
      orbit_rise_q <= orbit_sync_in & ~orbit_in_q;
    end
  end

  assign orbit_restart = orbit_rise_q;
`else
  assign orbit_restart = 1'b0;
`endif

  // Everything is decided on the next BX value so l1a_out and orbit_sync line up with bx_count.
  always_comb begin
    bx_next = 12'd0;
    if (enable && running && !orbit_restart && (bx_count != BX_LAST))
      bx_next = bx_count + 12'd1;

    cand_sw       = (mode == MODE_SOFTWARE) && l1a_pending;
    cand_periodic = (mode == MODE_PERIODIC) && (l1a_period != 16'd0) &&
                    (period_cnt == (l1a_period - 16'd1));
    cand_bx       = (mode == MODE_BX_LOCKED) && ({1'b0, l1a_bx} < BX_LIMIT) &&
                    (bx_next == l1a_bx);

    issue = enable && (cand_sw || cand_periodic || cand_bx) && (holdoff == 8'd0);
    drop  = enable && (cand_periodic || cand_bx) && (holdoff != 8'd0);

    period_next = 16'd0;
    if (enable && (mode == MODE_PERIODIC) && (l1a_period != 16'd0) &&
        (period_cnt < (l1a_period - 16'd1)))
      period_next = period_cnt + 16'd1;

    holdoff_next = 8'd0;
    if (enable) begin
      if (issue)
        holdoff_next = min_spacing;
      else if (holdoff != 8'd0)
        holdoff_next = holdoff - 8'd1;
    end

    // A request in the issuing cycle re-arms; leaving software mode drops the request.
    pending_next = enable && (mode == MODE_SOFTWARE) &&
                   (l1a_request || (l1a_pending && !issue));
  end

  always_ff @(posedge clk40 or posedge rst) begin
    if (rst) begin
      running     <= 1'b0;
      bx_count    <= 12'd0;
      orbit_sync  <= 1'b0;
      l1a_out     <= 1'b0;
      l1a_pending <= 1'b0;
      period_cnt  <= 16'd0;
      holdoff     <= 8'd0;
    end else begin
      running     <= enable;
      bx_count    <= bx_next;
      orbit_sync  <= enable && (bx_next == 12'd0);
      l1a_out     <= issue;
      l1a_pending <= pending_next;
      period_cnt  <= period_next;
      holdoff     <= holdoff_next;
    end
  end

  // A clear takes priority over an increment landing in the same cycle.
  always_ff @(posedge clk40 or posedge rst) begin
    if (rst) begin
      l1a_count   <= 32'd0;
      l1a_dropped <= 16'd0;
    end else if (count_clear) begin
      l1a_count   <= 32'd0;
      l1a_dropped <= 16'd0;
    end else begin
      if (issue)
        l1a_count <= l1a_count + 32'd1;
      if (drop && (l1a_dropped != 16'hFFFF))
        l1a_dropped <= l1a_dropped + 16'd1;
    end
  end

endmodule

// File: tb/tb_fast_cmd_gen.sv
// Directed testbench for fast_cmd_gen: reset, BX wrap, the three L1A modes, spacing and counters.
`timescale 1ns/1ps
module tb_fast_cmd_gen;

  logic        clk40 = 1'b0;
  logic        rst;
  logic        enable;
  logic [1:0]  l1a_mode;
  logic        l1a_request;
  logic [15:0] l1a_period;
  logic [11:0] l1a_bx;
  logic [7:0]  min_spacing;
  logic        count_clear;
`ifdef FAST_CMD_EXT_ORBIT_EN
  logic        orbit_sync_in;
`endif
  logic [11:0] bx_count;
  logic        orbit_sync;
  logic        l1a_out;
  logic        l1a_pending;
  logic [31:0] l1a_count;
  logic [15:0] l1a_dropped;

  int errors = 0;
  int checks = 0;

  fast_cmd_gen #(.BX_PER_ORBIT(3564)) dut (
    .clk40         (clk40),
    .rst           (rst),
    .enable        (enable),
    .l1a_mode      (l1a_mode),
    .l1a_request   (l1a_request),
    .l1a_period    (l1a_period),
    .l1a_bx        (l1a_bx),
    .min_spacing   (min_spacing),
    .count_clear   (count_clear),
`ifdef FAST_CMD_EXT_ORBIT_EN
    .orbit_sync_in (orbit_sync_in),
`endif
    .bx_count      (bx_count),
    .orbit_sync    (orbit_sync),
    .l1a_out       (l1a_out),
    .l1a_pending   (l1a_pending),
    .l1a_count     (l1a_count),
    .l1a_dropped   (l1a_dropped)
  );

  always #5 clk40 = ~clk40;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [1:0] mode, input logic [15:0] period,
                               input logic [11:0] bx, input logic [7:0] spacing);
    l1a_mode    = mode;
    l1a_period  = period;
    l1a_bx      = bx;
    min_spacing = spacing;
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(negedge clk40);
  endtask

  task automatic pulseClear();
    count_clear = 1'b1;
    @(negedge clk40);
    count_clear = 1'b0;
  endtask

  // Watches l1a_out for n cycles and summarises where the pulses landed.
  task automatic countPulses(input int n, output int pulses, output int first,
                             output int gapMin, output int gapMax,
                             output int firstBx, output int lastBx);
    int last;
    pulses = 0; first = -1; last = -1; gapMin = 1000000; gapMax = 0;
    firstBx = -1; lastBx = -1;
    for (int k = 1; k <= n; k++) begin
      @(negedge clk40);
      if (l1a_out) begin
        if (last >= 0) begin
          if (k - last < gapMin) gapMin = k - last;
          if (k - last > gapMax) gapMax = k - last;
        end else begin
          first   = k;
          firstBx = int'(bx_count);
        end
        last   = k;
        lastBx = int'(bx_count);
        pulses++;
      end
    end
  endtask

  initial begin
    #1200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int pulses, first, gapMin, gapMax, firstBx, lastBx;
    int hitN;
    int orbitHits [3];
    int p1, p2;

    rst = 1'b1; enable = 1'b0; l1a_request = 1'b0; count_clear = 1'b0;
    applyStimulus(2'd0, 16'd0, 12'd0, 8'd0);
`ifdef FAST_CMD_EXT_ORBIT_EN
    orbit_sync_in = 1'b0;
`endif
    for (int i = 0; i < 3; i++) orbitHits[i] = -1;
    waitCycles(3);

    rst = 1'b0; enable = 1'b1;
    @(negedge clk40);
    checkOutput("first_enabled_bx", 32'(bx_count), 0);
    checkOutput("first_enabled_orbit", 32'(orbit_sync), 1);
    waitCycles(1500);
    checkOutput("free_run_bx", 32'(bx_count), 1500);

    applyStimulus(2'd2, 16'd10, 12'd0, 8'd0);
    waitCycles(50);
    checkOutput("pre_reset_count", l1a_count, 5);

    rst = 1'b1;
    #1;
    checkOutput("rst_bx", 32'(bx_count), 0);
    checkOutput("rst_orbit", 32'(orbit_sync), 0);
    checkOutput("rst_l1a_out", 32'(l1a_out), 0);
    checkOutput("rst_pending", 32'(l1a_pending), 0);
    checkOutput("rst_count", l1a_count, 0);
    checkOutput("rst_dropped", 32'(l1a_dropped), 0);
    applyStimulus(2'd0, 16'd0, 12'd0, 8'd0);
    waitCycles(2);
    rst = 1'b0;

    hitN = 0;
    for (int c = 0; c <= 7130; c++) begin
      @(negedge clk40);
      if (orbit_sync) begin
        if (hitN < 3) orbitHits[hitN] = c;
        hitN++;
      end
      if (c == 3563) checkOutput("wrap_before_bx", 32'(bx_count), 3563);
      if (c == 3564) checkOutput("wrap_after_bx", 32'(bx_count), 0);
    end
    checkOutput("orbit_pulse_count", hitN, 3);
    checkOutput("orbit_hit0", orbitHits[0], 0);
    checkOutput("orbit_hit1", orbitHits[1], 3564);
    checkOutput("orbit_hit2", orbitHits[2], 7128);

    pulseClear();
    checkOutput("clear_count", l1a_count, 0);
    applyStimulus(2'd2, 16'd10, 12'd0, 8'd0);
    countPulses(1000, pulses, first, gapMin, gapMax, firstBx, lastBx);
    checkOutput("periodic_pulses", pulses, 100);
    checkOutput("periodic_first", first, 10);
    checkOutput("periodic_gap_min", gapMin, 10);
    checkOutput("periodic_gap_max", gapMax, 10);
    checkOutput("periodic_count", l1a_count, 100);
    checkOutput("periodic_dropped", 32'(l1a_dropped), 0);

    applyStimulus(2'd3, 16'd10, 12'd100, 8'd0);
    countPulses(7128, pulses, first, gapMin, gapMax, firstBx, lastBx);
    checkOutput("bxlock_pulses", pulses, 2);
    checkOutput("bxlock_first_bx", firstBx, 100);
    checkOutput("bxlock_last_bx", lastBx, 100);
    checkOutput("bxlock_gap", gapMin, 3564);
    checkOutput("bxlock_count", l1a_count, 102);

    applyStimulus(2'd0, 16'd3, 12'd100, 8'd5);
    pulseClear();
    applyStimulus(2'd2, 16'd3, 12'd100, 8'd5);
    countPulses(60, pulses, first, gapMin, gapMax, firstBx, lastBx);
    checkOutput("holdoff_pulses", pulses, 10);
    checkOutput("holdoff_first", first, 3);
    checkOutput("holdoff_gap_min", gapMin, 6);
    checkOutput("holdoff_gap_max", gapMax, 6);
    checkOutput("holdoff_count", l1a_count, 10);
    checkOutput("holdoff_dropped", 32'(l1a_dropped), 10);

    applyStimulus(2'd0, 16'd0, 12'd0, 8'd20);
    waitCycles(10);
    applyStimulus(2'd1, 16'd0, 12'd0, 8'd20);
    l1a_request = 1'b1;
    pulses = 0; p1 = -1; p2 = -1;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk40);
      if (l1a_out) begin
        if (pulses == 0) p1 = k;
        if (pulses == 1) p2 = k;
        pulses++;
      end
      if (k == 1)  checkOutput("pend_k1", 32'(l1a_pending), 1);
      if (k == 2)  checkOutput("pend_k2", 32'(l1a_pending), 0);
      if (k == 5)  checkOutput("pend_k5", 32'(l1a_pending), 1);
      if (k == 22) checkOutput("pend_k22", 32'(l1a_pending), 1);
      if (k == 23) checkOutput("pend_k23", 32'(l1a_pending), 0);
      if (k == 1) l1a_request = 1'b0;
      if (k == 4) l1a_request = 1'b1;
      if (k == 5) l1a_request = 1'b0;
    end
    checkOutput("sw_pulses", pulses, 2);
    checkOutput("sw_first", p1, 2);
    checkOutput("sw_second", p2, 23);

    applyStimulus(2'd0, 16'd0, 12'd0, 8'd0);
    waitCycles(20);
    pulseClear();
    applyStimulus(2'd1, 16'd0, 12'd0, 8'd0);
    l1a_request = 1'b1;
    pulses = 0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk40);
      if (l1a_out) pulses++;
    end
    checkOutput("rearm_pulses", pulses, 7);
    checkOutput("rearm_count", l1a_count, 7);
    count_clear = 1'b1;
    @(negedge clk40);
    checkOutput("collide_l1a_out", 32'(l1a_out), 1);
    checkOutput("collide_count", l1a_count, 0);
    count_clear = 1'b0; l1a_request = 1'b0;
    @(negedge clk40);
    checkOutput("after_collide_count", l1a_count, 1);
    @(negedge clk40);
    checkOutput("after_collide_idle", 32'(l1a_out), 0);
    checkOutput("after_collide_pend", 32'(l1a_pending), 0);

    l1a_request = 1'b1;
    @(negedge clk40);
    checkOutput("pend_before_disable", 32'(l1a_pending), 1);
    enable = 1'b0; l1a_request = 1'b0;
    @(negedge clk40);
    checkOutput("disable_pending", 32'(l1a_pending), 0);
    checkOutput("disable_bx", 32'(bx_count), 0);
    checkOutput("disable_orbit", 32'(orbit_sync), 0);
    checkOutput("disable_l1a_out", 32'(l1a_out), 0);
    checkOutput("disable_count_kept", l1a_count, 1);
    enable = 1'b1;
    applyStimulus(2'd0, 16'd0, 12'd0, 8'd0);
    @(negedge clk40);
    checkOutput("reenable_bx", 32'(bx_count), 0);
    checkOutput("reenable_orbit", 32'(orbit_sync), 1);
    @(negedge clk40);
    checkOutput("reenable_bx_next", 32'(bx_count), 1);

`ifdef FAST_CMD_EXT_ORBIT_EN
    for (int n = 0; n < 4000 && bx_count != 12'd1234; n++) @(negedge clk40);
    checkOutput("ext_reach_1234", 32'(bx_count), 1234);
    orbit_sync_in = 1'b1;
    @(negedge clk40);
    checkOutput("ext_bx_1235", 32'(bx_count), 1235);
    orbit_sync_in = 1'b0;
    @(negedge clk40);
    checkOutput("ext_bx_zero", 32'(bx_count), 0);
    checkOutput("ext_orbit", 32'(orbit_sync), 1);
    @(negedge clk40);
    checkOutput("ext_bx_one", 32'(bx_count), 1);
`endif

    pulseClear();
    applyStimulus(2'd2, 16'd1, 12'd0, 8'd255);
    for (int n = 0; n < 70000 && l1a_dropped != 16'hFFFF; n++) @(negedge clk40);
    checkOutput("dropped_sat_reached", 32'(l1a_dropped), 32'h0000FFFF);
    waitCycles(600);
    checkOutput("dropped_sat_held", 32'(l1a_dropped), 32'h0000FFFF);
    pulseClear();
    checkOutput("dropped_cleared", 32'(l1a_dropped), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
